// File: rtl/light_7seg_decoder_pkg.sv
// Shared seven-segment display constants: segment bit positions, hex glyph table, blank pattern.
// All patterns are active-high with dp in bit 0; polarity is applied by each driver.
package light_7seg_decoder_pkg;

   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   // Element i is the glyph for nibble i; b and d are lowercase so they differ from 8 and 0.
   localparam logic [15:0][7:0] SEG_HEX = {
      8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
   };

   localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/light_7seg_decoder_seg_hex_lut.sv
// Combinational nibble to a..g lookup, active-high, bit 6 = a down to bit 0 = g.
// Zero latency; no flow control.
module light_7seg_decoder_seg_hex_lut
   import light_7seg_decoder_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   logic [7:0] glyph;

   always_comb begin
      glyph = SEG_HEX[nib_i];
      seg_o = glyph[SEG_A:SEG_G];
   end

endmodule

// File: rtl/light_7seg_decoder.sv
// Hex digit to seven-segment pattern with dp, blanking and selectable polarity.
// REGISTERED=1: 1-cycle latency, sync reset to blank; REGISTERED=0: combinational. No backpressure.
module light_7seg_decoder
   import light_7seg_decoder_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b0,
   parameter bit REGISTERED = 1'b1
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] seg_in,
   input  logic       dp_in,
   input  logic       blank,
   output logic [7:0] seg_out
);

   localparam logic [7:0] BLANK_OUT = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

   logic [6:0] lut_seg;
   logic [7:0] raw;
   logic [7:0] seg_d;

   light_7seg_decoder_seg_hex_lut u_lut (
      .nib_i (seg_in),
      .seg_o (lut_seg)
   );

   // Blanking overrides dp; inversion comes last so blank maps to all-off in either polarity.
   always_comb begin
      raw   = blank ? SEG_BLANK : {lut_seg, dp_in};
      seg_d = ACTIVE_LOW ? ~raw : raw;
   end

   generate
      if (REGISTERED) begin : g_reg
         logic [7:0] seg_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               seg_q <= BLANK_OUT;
            end else begin
               seg_q <= seg_d;
            end
         end

         assign seg_out = seg_q;
      end else begin : g_comb
         logic unused_clk_rst;

         assign unused_clk_rst = clk ^ rst;
         assign seg_out        = seg_d;
      end
   endgenerate

endmodule

// File: tb/tb_light_7seg_decoder.sv
// Directed and random checks of the registered (both polarities) and combinational builds.
module tb_light_7seg_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] seg_in = 4'h0;
   logic       dp_in = 1'b0;
   logic       blank = 1'b0;
   logic [7:0] seg_r0, seg_r1, seg_c;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_r0, exp_r1;
   logic       exp_valid = 1'b0;

   // Lit segments of each glyph, by letter name.
   string LETTERS [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   always #5 clk = ~clk;

   light_7seg_decoder #(.ACTIVE_LOW(1'b0), .REGISTERED(1'b1)) u_r0 (
      .clk(clk), .rst(rst), .seg_in(seg_in), .dp_in(dp_in), .blank(blank), .seg_out(seg_r0));
   light_7seg_decoder #(.ACTIVE_LOW(1'b1), .REGISTERED(1'b1)) u_r1 (
      .clk(clk), .rst(rst), .seg_in(seg_in), .dp_in(dp_in), .blank(blank), .seg_out(seg_r1));
   light_7seg_decoder #(.ACTIVE_LOW(1'b0), .REGISTERED(1'b0)) u_c (
      .clk(clk), .rst(rst), .seg_in(seg_in), .dp_in(dp_in), .blank(blank), .seg_out(seg_c));

   function automatic logic [7:0] model(input logic [3:0] n, input logic d, input logic b,
                                        input logic al);
      string      s;
      logic [7:0] raw;
      int         k;
      s   = LETTERS[n];
      raw = {7'b0, d};
      for (int i = 0; i < s.len(); i++) begin
         k = int'(s[i]) - 97;
         raw[7 - k] = 1'b1;
      end
      if (b) raw = 8'h00;
      return al ? ~raw : raw;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Apply inputs mid-cycle, check comb output and that registered outputs have not moved yet,
   // then check registered outputs one edge later.
   task automatic step(input logic r, input logic [3:0] n, input logic d, input logic b);
      rst = r; seg_in = n; dp_in = d; blank = b;
      #1;
      check("comb", seg_c, model(n, d, b, 1'b0));
      if (exp_valid) begin
         check("hold_al0", seg_r0, exp_r0);
         check("hold_al1", seg_r1, exp_r1);
      end
      @(posedge clk);
      #1;
      exp_r0    = r ? 8'h00 : model(n, d, b, 1'b0);
      exp_r1    = r ? 8'hFF : model(n, d, b, 1'b1);
      exp_valid = 1'b1;
      check("reg_al0", seg_r0, exp_r0);
      check("reg_al1", seg_r1, exp_r1);
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset with seg_in=8, then release.
      step(1'b1, 4'h8, 1'b0, 1'b0);
      check("rst_al0", seg_r0, 8'h00);
      check("rst_al1", seg_r1, 8'hFF);
      step(1'b1, 4'h8, 1'b0, 1'b0);
      step(1'b0, 4'h8, 1'b0, 1'b0);
      check("rel_8", seg_r0, 8'hFE);

      // Full sweep.
      for (int i = 0; i < 16; i++) step(1'b0, 4'(i), 1'b0, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b0);
      check("sweep_0", seg_r0, 8'hFC);
      check("al1_0", seg_r1, 8'h03);
      step(1'b0, 4'h5, 1'b0, 1'b0);
      check("sweep_5", seg_r0, 8'hB6);
      step(1'b0, 4'hF, 1'b0, 1'b0);
      check("sweep_F", seg_r0, 8'h8E);

      // Decimal point.
      step(1'b0, 4'h3, 1'b1, 1'b0);
      check("dp_on", seg_r0, 8'hF3);
      step(1'b0, 4'h3, 1'b0, 1'b0);
      check("dp_off", seg_r0, 8'hF2);

      // Blank priority over dp, then release.
      step(1'b0, 4'h8, 1'b1, 1'b1);
      check("blank_al0", seg_r0, 8'h00);
      check("blank_al1", seg_r1, 8'hFF);
      step(1'b0, 4'h8, 1'b1, 1'b0);
      check("unblank", seg_r0, 8'hFF);

      // blank and seg_in change together: blank wins.
      step(1'b0, 4'h2, 1'b0, 1'b1);
      check("blank_same", seg_r0, 8'h00);

      // Mid-display reset blanks one edge only.
      step(1'b0, 4'h6, 1'b0, 1'b0);
      step(1'b1, 4'h6, 1'b1, 1'b0);
      check("mid_rst", seg_r0, 8'h00);
      step(1'b0, 4'h6, 1'b0, 1'b0);
      check("post_rst", seg_r0, 8'hBE);

      // Combinational build ignores rst.
      step(1'b0, 4'h1, 1'b0, 1'b0);
      check("comb_1", seg_c, 8'h60);
      rst = 1'b1;
      #1;
      check("comb_rst", seg_c, 8'h60);
      step(1'b1, 4'h1, 1'b0, 1'b0);

      // Random stimulus.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
